ksa_engine: RTL and testbench

- Downstream consumer of key_generator; one instance runs per candidate key.
- Takes a 24-bit candidate key and runs the RC4 key-scheduling algorithm on an external 256x8 S-memory.
- First fills the memory with the identity permutation, then performs 256 swap iterations.
- Signals completion with a single-cycle finished pulse, so the next stage (PRGA/decrypt) can start. key_generator's own handshake is unchanged.

---
 rtl/rc4_pkg.sv | 47 ++++
 rtl/ksa_engine_if.sv | 42 ++++
 rtl/ksa_engine.sv | 191 +++++++++++++++++++
 tb/tb_ksa_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
//   Shared definitions for the RC4 key-scheduling engine (ksa_engine) and its
//   bus interface.
//
//   S_DEPTH     : number of entries in the S-memory permutation (256).
//   KEY_BYTES   : candidate key length in bytes (3, i.e. a 24-bit key).
//   ksa_state_t : control states of the key-scheduling FSM.
//   key_byte()  : selects key byte idx, where byte 0 is the most significant
//                 byte of the key word.
// -----------------------------------------------------------------------------
package rc4_pkg;

   localparam int S_DEPTH   = 256;
   localparam int KEY_BYTES = 3;

   // IDLE   : waiting for start
   // INIT   : identity fill, one write per cycle
   // RD_I.. : one swap iteration, seven cycles (RD_I through WR_J)
   // DONE   : completion pulse, back to IDLE
   typedef enum logic [3:0] {
      IDLE,
      INIT,
      RD_I,
      WT_I,
      CAP_I,
      WT_J,
      CAP_J,
      WR_I,
      WR_J,
      DONE
   } ksa_state_t;

   // Byte 0 sits in the top byte of the key word, byte KEY_BYTES-1 at the
   // bottom. The loop unrolls into a small mux; idx values past the last
   // byte fall back to byte 0.
   function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                           input logic [1:0]             idx);
      logic [7:0] b;
      b = key[8*KEY_BYTES-1 -: 8];
      for (int k = 1; k < KEY_BYTES; k++) begin
         if (int'(idx) == k) b = key[8*(KEY_BYTES-k)-1 -: 8];
      end
      return b;
   endfunction

endpackage

// File: rtl/ksa_engine_if.sv
// -----------------------------------------------------------------------------
// ksa_engine_if
//   Groups the request handshake and the S-memory port of ksa_engine.
//
//   start      : run request from the key generator side
//   key        : candidate key, captured when start is accepted
//   busy       : engine is running
//   finished   : one-cycle completion pulse
//   mem_addr   : S-memory address (registered in the engine)
//   mem_wdata  : S-memory write data (registered in the engine)
//   mem_wren   : S-memory write enable (registered in the engine)
//   mem_rdata  : S-memory read data, returned by the memory one cycle after
//                the address appears on mem_addr
//
//   master : the parent side (drives start/key, owns the memory)
//   slave  : the engine side
// -----------------------------------------------------------------------------
interface ksa_engine_if #(
   parameter int KEY_W  = 8 * rc4_pkg::KEY_BYTES,
   parameter int ADDR_W = 8
);

   logic              start;
   logic [KEY_W-1:0]  key;
   logic              busy;
   logic              finished;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_wren;
   logic [7:0]        mem_rdata;

   modport master (
      output start, key, mem_rdata,
      input  busy, finished, mem_addr, mem_wdata, mem_wren
   );

   modport slave (
      input  start, key, mem_rdata,
      output busy, finished, mem_addr, mem_wdata, mem_wren
   );

endinterface

// File: rtl/ksa_engine.sv
// -----------------------------------------------------------------------------
// ksa_engine
//   RC4 key-scheduling engine for one 24-bit candidate key. Drives an external
//   256x8 S-memory: fills it with the identity permutation, then runs the 256
//   swap iterations of the RC4 KSA. A one-cycle finished pulse tells the next
//   stage (PRGA/decrypt) that the permutation is ready.
//
//   Ports:
//     clk    : system clock, rising edge
//     reset  : asynchronous, active-low reset
//     bus    : ksa_engine_if.slave
//                start/key      -> request, sampled only in IDLE
//                busy/finished  <- status
//                mem_addr/mem_wdata/mem_wren -> S-memory command (registered)
//                mem_rdata      <- S-memory read data
//
//   Timing model:
//     Every memory command is computed in a state and registered, so it
//     appears on the bus one cycle later; the memory returns read data one
//     cycle after that. A read issued in state X can therefore be captured
//     two states later, which is why RD_I/WT_I/CAP_I and CAP_I/WT_J/CAP_J
//     are spaced as they are.
//
//     accept edge -> 256 INIT cycles -> 256 x 7 swap cycles -> DONE, with
//     finished visible 2049 cycles after the accepting edge.
// -----------------------------------------------------------------------------
module ksa_engine #(
   parameter int KEY_BYTES  = 3,
   parameter int ADDR_WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   ksa_engine_if.slave bus
);

   import rc4_pkg::*;

   // Key byte index counts 0..KEY_BYTES-1 alongside i, avoiding an i mod 3.
   localparam logic [1:0]            KIDX_LAST = 2'(KEY_BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] I_LAST    = '1;
   localparam logic [ADDR_WIDTH-1:0] I_ONE     = ADDR_WIDTH'(1);

   ksa_state_t             state, state_n;

   logic [ADDR_WIDTH-1:0]  i, i_n;
   logic [ADDR_WIDTH-1:0]  j, j_n;
   logic [1:0]             kidx, kidx_n;
   logic [8*KEY_BYTES-1:0] key_q, key_n;
   logic [7:0]             si, si_n;
   logic [7:0]             sj, sj_n;

   logic [ADDR_WIDTH-1:0]  addr_q, addr_n;
   logic [7:0]             wdata_q, wdata_n;
   logic                   wren_q, wren_n;
   logic                   busy_q, busy_n;
   logic                   fin_q, fin_n;

   // --------------------------------------------------------------------------
   // State and datapath registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         i       <= '0;
         j       <= '0;
         kidx    <= '0;
         key_q   <= '0;
         si      <= '0;
         sj      <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wren_q  <= 1'b0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state   <= state_n;
         i       <= i_n;
         j       <= j_n;
         kidx    <= kidx_n;
         key_q   <= key_n;
         si      <= si_n;
         sj      <= sj_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
         wren_q  <= wren_n;
         busy_q  <= busy_n;
         fin_q   <= fin_n;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and next-output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_n = state;
      i_n     = i;
      j_n     = j;
      kidx_n  = kidx;
      key_n   = key_q;
      si_n    = si;
      sj_n    = sj;
      addr_n  = addr_q;
      wdata_n = wdata_q;
      wren_n  = 1'b0;       // write enable is a per-cycle strobe
      busy_n  = busy_q;
      fin_n   = 1'b0;       // finished is a single-cycle pulse

      case (state)
         IDLE: begin
            if (bus.start) begin
               key_n   = bus.key;
               i_n     = '0;
               j_n     = '0;
               kidx_n  = '0;
               busy_n  = 1'b1;
               state_n = INIT;
            end
         end

         // S[i] = i for all i; i wraps back to 0 on the last entry, which is
         // exactly the starting index of the swap phase.
         INIT: begin
            addr_n  = i;
            wdata_n = 8'(i);
            wren_n  = 1'b1;
            i_n     = i + I_ONE;
            if (i == I_LAST) state_n = RD_I;
         end

         RD_I: begin
            addr_n  = i;
            state_n = WT_I;
         end

         WT_I: state_n = CAP_I;

         // S[i] is on mem_rdata now. The new j goes straight into the
         // address register so the S[j] read starts without an extra cycle.
         CAP_I: begin
            si_n    = bus.mem_rdata;
            j_n     = j + ADDR_WIDTH'(bus.mem_rdata)
                        + ADDR_WIDTH'(key_byte(key_q, kidx));
            addr_n  = j_n;
            state_n = WT_J;
         end

         WT_J: state_n = CAP_J;

         CAP_J: begin
            sj_n    = bus.mem_rdata;
            state_n = WR_I;
         end

         // When j == i both writes land on the same entry with the same
         // value, so no special case is needed.
         WR_I: begin
            addr_n  = i;
            wdata_n = sj;
            wren_n  = 1'b1;
            state_n = WR_J;
         end

         WR_J: begin
            addr_n  = j;
            wdata_n = si;
            wren_n  = 1'b1;
            i_n     = i + I_ONE;
            kidx_n  = (kidx == KIDX_LAST) ? 2'd0 : kidx + 2'd1;
            state_n = (i == I_LAST) ? DONE : RD_I;
         end

         DONE: begin
            fin_n   = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end

         default: begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   assign bus.busy      = busy_q;
   assign bus.finished  = fin_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wren  = wren_q;

endmodule

// File: tb/tb_ksa_engine.sv
// -----------------------------------------------------------------------------
// tb_ksa_engine
//   Bench for ksa_engine. Provides the 256x8 S-memory (registered read data),
//   a behavioural RC4 KSA model that predicts the full write stream and the
//   final permutation for each accepted key, a per-cycle compare process, and
//   directed runs with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_ksa_engine;

   import rc4_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   ksa_engine_if bus ();

   ksa_engine #(
      .KEY_BYTES  (3),
      .ADDR_WIDTH (8)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   // S-memory: write and registered read on the rising edge.
   logic [7:0] mem [256];

   always @(posedge clk) begin
      if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                  nm, act, act, exp, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: plain RC4 KSA producing the ordered write stream
   // {addr,data} and the final permutation.
   // ---------------------------------------------------------------------------
   logic [15:0] exp_q [$];
   logic [15:0] wr_log [$];
   logic [7:0]  gold [256];

   function automatic void build_model(input logic [23:0] k);
      logic [7:0] s [256];
      logic [7:0] jj;
      logic [7:0] t;
      exp_q.delete();
      for (int n = 0; n < 256; n++) begin
         s[n] = 8'(n);
         exp_q.push_back({8'(n), 8'(n)});
      end
      jj = 8'd0;
      for (int n = 0; n < 256; n++) begin
         jj = jj + s[n] + k[23-8*(n%3) -: 8];
         exp_q.push_back({8'(n), s[jj]});   // S[i] <= old S[j]
         exp_q.push_back({jj, s[n]});       // S[j] <= old S[i]
         t     = s[n];
         s[n]  = s[jj];
         s[jj] = t;
      end
      for (int n = 0; n < 256; n++) gold[n] = s[n];
   endfunction

   // Protocol model: a run lasts 2049 cycles from the accepting edge, start
   // is only looked at when no run is active.
   int cyc     = 0;
   int acc_cyc = 0;
   int run_cnt = 0;
   int m_act   = 0;
   int m_busy  = 0;
   int m_fin   = 0;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            m_act  = 0;
            m_busy = 0;
            m_fin  = 0;
            exp_q.delete();
         end else if (m_act != 0) begin
            run_cnt++;
            if (run_cnt == 2049) begin
               m_act  = 0;
               m_busy = 0;
               m_fin  = 1;
            end
         end else begin
            m_fin = 0;
            if (bus.start) begin
               m_act   = 1;
               m_busy  = 1;
               run_cnt = 0;
               acc_cyc = cyc;
               build_model(bus.key);
            end
         end
      end
   end

   // Compare process: status every cycle, every write against the model.
   initial begin
      logic [15:0] e;
      logic [15:0] w;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("busy", int'(bus.busy), m_busy);
            chk("finished", int'(bus.finished), m_fin);
            if (bus.mem_wren) begin
               w = {bus.mem_addr, bus.mem_wdata};
               wr_log.push_back(w);
               chk("write_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("write_addr_data", int'(w), int'(e));
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus
   // ---------------------------------------------------------------------------
   task automatic check_mem(input string nm);
      for (int n = 0; n < 256; n++)
         chk($sformatf("%s_S[%0d]", nm, n), int'(mem[n]), int'(gold[n]));
   endtask

   // Waits for finished (bounded), optionally scrambling the key input every
   // cycle, and returns the latency from the accepting edge.
   task automatic wait_fin(input string nm, input int bound, input bit toggle,
                           output int lat);
      lat = -1;
      for (int n = 0; n < bound && lat < 0; n++) begin
         if (toggle) bus.key = 24'($urandom);
         @(negedge clk);
         if (bus.finished) lat = cyc - acc_cyc;
      end
      chk({nm, "_finished_seen"}, int'(lat >= 0), 1);
   endtask

   task automatic run(input logic [23:0] k, input bit toggle, input string nm);
      int lat;
      int bad;
      @(negedge clk);
      wr_log.delete();
      bus.key   = k;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk({nm, "_busy_after_accept"}, int'(bus.busy), 1);
      wait_fin(nm, 2100, toggle, lat);
      chk({nm, "_latency"}, lat, 2049);
      @(negedge clk);
      chk({nm, "_finished_width"}, int'(bus.finished), 0);
      chk({nm, "_busy_after_done"}, int'(bus.busy), 0);
      chk({nm, "_write_count"}, wr_log.size(), 768);
      bad = 0;
      for (int n = 0; n < 256 && n < wr_log.size(); n++)
         if (wr_log[n] != {8'(n), 8'(n)}) bad++;
      chk({nm, "_init_writes"}, bad, 0);
      check_mem(nm);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int runs;
      int fins;
      int prev_busy;
      int fin_at;
      int rise2;
      int lat;

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.key   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_finished", int'(bus.finished), 0);
      chk("rst_wren", int'(bus.mem_wren), 0);
      chk("rst_addr", int'(bus.mem_addr), 0);
      chk("rst_wdata", int'(bus.mem_wdata), 0);
      chk("rst_state", int'(dut.state), int'(IDLE));
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Key 0: identity fill, self-swaps at i=0, i=2 swaps entries 2 and 3.
      run(24'h000000, 1'b0, "k0");
      chk("k0_swap0_wr_i", int'(wr_log[256]), 'h0000);
      chk("k0_swap0_wr_j", int'(wr_log[257]), 'h0000);
      chk("k0_swap2_wr_i", int'(wr_log[260]), 'h0203);
      chk("k0_swap2_wr_j", int'(wr_log[261]), 'h0302);

      // Key 00033C: i=1 -> j=4, i=2 -> j=0x42.
      run(24'h00033C, 1'b0, "k33c");
      chk("k33c_swap1_wr_i", int'(wr_log[258]), 'h0104);
      chk("k33c_swap1_wr_j", int'(wr_log[259]), 'h0401);
      chk("k33c_swap2_wr_i", int'(wr_log[260]), 'h0242);
      chk("k33c_swap2_wr_j", int'(wr_log[261]), 'h4202);

      // start held high for 3000 cycles: two runs, back to back.
      @(negedge clk);
      bus.key   = 24'h5A17C3;
      bus.start = 1'b1;
      runs = 0; fins = 0; prev_busy = 0; fin_at = -1; rise2 = -1;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (bus.busy && prev_busy == 0) begin
            runs++;
            if (runs == 2) rise2 = cyc;
         end
         if (bus.finished) begin
            fins++;
            fin_at = cyc;
         end
         prev_busy = int'(bus.busy);
      end
      bus.start = 1'b0;
      chk("held_runs_started", runs, 2);
      chk("held_finishes_in_window", fins, 1);
      chk("held_restart_gap", rise2 - fin_at, 1);
      wait_fin("held2", 2100, 1'b0, lat);
      chk("held2_latency", lat, 2049);
      @(negedge clk);
      check_mem("held2");

      // Key scrambled every cycle while busy: the latched copy is used.
      run(24'hC0FFEE, 1'b1, "tog");

      // Reset in the middle of a run (cycle 900 is RD_I with the previous
      // WR_J write still on the bus).
      @(negedge clk);
      wr_log.delete();
      bus.key   = 24'h123456;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (900) @(posedge clk);
      #2;
      chk("abort_pre_wren", int'(bus.mem_wren), 1);
      chk("abort_pre_busy", int'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_finished", int'(bus.finished), 0);
      chk("abort_wren", int'(bus.mem_wren), 0);
      chk("abort_state", int'(dut.state), int'(IDLE));
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      run(24'h654321, 1'b0, "post_rst");

      // Key FFFFFF: j = 0 + 0 + 255 on the first iteration.
      run(24'hFFFFFF, 1'b0, "kff");
      chk("kff_swap0_wr_i", int'(wr_log[256]), 'h00FF);
      chk("kff_swap0_wr_j", int'(wr_log[257]), 'hFF00);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
